// File: rtl/eth_rx_word_packer.sv
// Receive-side payload packer: filters frames by destination MAC and packs the byte stream
// into 64-bit little-endian words tagged with byte count, source MAC and ethertype.
module eth_rx_word_packer #(
    parameter int unsigned MAX_PAYLOAD = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] cfg_local_mac,
    input  logic        cfg_promisc,
    input  logic        s_eth_hdr_valid,
    output logic        s_eth_hdr_ready,
    input  logic [47:0] s_eth_dest_mac,
    input  logic [47:0] s_eth_src_mac,
    input  logic [15:0] s_eth_type,
    input  logic [7:0]  s_payload_tdata,
    input  logic        s_payload_tvalid,
    output logic        s_payload_tready,
    input  logic        s_payload_tlast,
    input  logic        s_payload_tuser,
    output logic [63:0] m_tdata,
    output logic [3:0]  m_tbytes,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic [15:0] m_frame_len,
    output logic [47:0] m_src_mac,
    output logic [15:0] m_type,
    output logic [31:0] stat_accepted,
    output logic [31:0] stat_dropped
);

    typedef enum logic [1:0] {StIdle, StPayload, StDrop} state_e;

    state_e      r_state;
    logic [63:0] r_acc;
    logic [2:0]  r_idx;
    logic [15:0] r_len;
    logic        r_ovf;
    logic [63:0] r_tdata;
    logic [3:0]  r_tbytes;
    logic        r_tvalid;
    logic        r_tlast;
    logic        r_tuser;
    logic [15:0] r_frame_len;
    logic [47:0] r_src_mac;
    logic [15:0] r_type;
    logic [31:0] r_stat_accepted;
    logic [31:0] r_stat_dropped;

    logic        w_hdr_ready;
    logic        w_pay_ready;
    logic        w_hdr_beat;
    logic        w_pay_beat;
    logic        w_dest_ok;
    logic        w_store;
    logic [15:0] w_len_inc;
    logic [63:0] w_lane_data;
    logic [63:0] w_word;
    logic [3:0]  w_fill;
    logic        w_emit;

    assign w_hdr_ready = (r_state == StIdle) && !r_tvalid;
    assign w_pay_ready = (r_state == StPayload) ? (!r_tvalid || m_tready) : (r_state == StDrop);
    assign w_hdr_beat  = s_eth_hdr_valid && w_hdr_ready;
    assign w_pay_beat  = s_payload_tvalid && w_pay_ready;

    assign w_dest_ok = cfg_promisc || (s_eth_dest_mac == cfg_local_mac)
                       || (s_eth_dest_mac == 48'hFFFF_FFFF_FFFF);

    // Bytes beyond the payload limit are counted but never stored.
    assign w_store     = {16'd0, r_len} < MAX_PAYLOAD;
    assign w_len_inc   = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
    assign w_lane_data = 64'(s_payload_tdata) << {r_idx, 3'b000};
    assign w_word      = r_acc | (w_store ? w_lane_data : 64'd0);
    assign w_fill      = w_store ? ({1'b0, r_idx} + 4'd1) : {1'b0, r_idx};
    assign w_emit      = w_pay_beat && (r_state == StPayload)
                         && ((w_store && (r_idx == 3'd7)) || s_payload_tlast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= StIdle;
            r_acc           <= '0;
            r_idx           <= '0;
            r_len           <= '0;
            r_ovf           <= 1'b0;
            r_tdata         <= '0;
            r_tbytes        <= '0;
            r_tvalid        <= 1'b0;
            r_tlast         <= 1'b0;
            r_tuser         <= 1'b0;
            r_frame_len     <= '0;
            r_src_mac       <= '0;
            r_type          <= '0;
            r_stat_accepted <= '0;
            r_stat_dropped  <= '0;
        end else begin
            if (r_tvalid && m_tready) begin
                r_tvalid <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    if (w_hdr_beat) begin
                        if (w_dest_ok) begin
                            r_src_mac <= s_eth_src_mac;
                            r_type    <= s_eth_type;
                            r_len     <= '0;
                            r_idx     <= '0;
                            r_ovf     <= 1'b0;
                            r_acc     <= '0;
                            r_state   <= StPayload;
                        end else begin
                            r_stat_dropped <= r_stat_dropped + 32'd1;
                            r_state        <= StDrop;
                        end
                    end
                end
                StPayload: begin
                    if (w_pay_beat) begin
                        r_len <= w_len_inc;
                        if (w_store) begin
                            r_acc <= w_word;
                            r_idx <= r_idx + 3'd1;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                        if (w_emit) begin
                            r_acc       <= '0;
                            r_tdata     <= w_word;
                            r_tbytes    <= w_fill;
                            r_tvalid    <= 1'b1;
                            r_tlast     <= s_payload_tlast;
                            r_tuser     <= s_payload_tlast
                                           && (s_payload_tuser || r_ovf || !w_store);
                            r_frame_len <= w_len_inc;
                        end
                        if (s_payload_tlast) begin
                            r_idx           <= '0;
                            r_stat_accepted <= r_stat_accepted + 32'd1;
                            r_state         <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (w_pay_beat && s_payload_tlast) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign s_eth_hdr_ready  = w_hdr_ready;
    assign s_payload_tready = w_pay_ready;
    assign m_tdata          = r_tdata;
    assign m_tbytes         = r_tbytes;
    assign m_tvalid         = r_tvalid;
    assign m_tlast          = r_tlast;
    assign m_tuser          = r_tuser;
    assign m_frame_len      = r_frame_len;
    assign m_src_mac        = r_src_mac;
    assign m_type           = r_type;
    assign stat_accepted    = r_stat_accepted;
    assign stat_dropped     = r_stat_dropped;

endmodule

// File: tb/tb_eth_rx_word_packer.sv
// Bench for eth_rx_word_packer: two instances (payload limit 1500 and 8) checked against a
// frame-level model that predicts every output word from the byte list of each frame.
module tb_eth_rx_word_packer;

    localparam logic [47:0] LocalMac = 48'h0200_0000_0001;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  bytes;
        logic        last;
        logic        user;
        logic [15:0] len;
        logic [47:0] src;
        logic [15:0] typ;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        cfg_promisc = 1'b0;
    logic        s_eth_hdr_valid = 1'b0;
    logic [47:0] s_eth_dest_mac = '0;
    logic [47:0] s_eth_src_mac = '0;
    logic [15:0] s_eth_type = '0;
    logic [7:0]  s_payload_tdata = '0;
    logic        s_payload_tvalid = 1'b0;
    logic        s_payload_tlast = 1'b0;
    logic        s_payload_tuser = 1'b0;
    logic        m_tready = 1'b1;
    int          rdy_mode = 0;

    int total = 0;
    int bad = 0;
    word_t exp_q[$];
    int exp_acc[2];
    int exp_drop[2];

    logic        d_hdr_ready[2], d_pay_ready[2], d_tvalid[2], d_tlast[2], d_tuser[2];
    logic [63:0] d_tdata[2];
    logic [3:0]  d_tbytes[2];
    logic [15:0] d_frame_len[2], d_type[2];
    logic [47:0] d_src_mac[2];
    logic [31:0] d_acc[2], d_drop[2];

    logic        o_hdr_ready, o_pay_ready, o_tvalid, o_tlast, o_tuser;
    logic [63:0] o_tdata;
    logic [3:0]  o_tbytes;
    logic [15:0] o_frame_len, o_type;
    logic [47:0] o_src_mac;
    logic [31:0] o_acc, o_drop;

    always #5 clk = ~clk;

    eth_rx_word_packer #(.MAX_PAYLOAD(1500)) dut (
        .clk(clk), .rst(rst), .cfg_local_mac(LocalMac), .cfg_promisc(cfg_promisc),
        .s_eth_hdr_valid(s_eth_hdr_valid && !sel), .s_eth_hdr_ready(d_hdr_ready[0]),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_payload_tdata(s_payload_tdata), .s_payload_tvalid(s_payload_tvalid && !sel),
        .s_payload_tready(d_pay_ready[0]), .s_payload_tlast(s_payload_tlast),
        .s_payload_tuser(s_payload_tuser), .m_tdata(d_tdata[0]), .m_tbytes(d_tbytes[0]),
        .m_tvalid(d_tvalid[0]), .m_tready(m_tready), .m_tlast(d_tlast[0]), .m_tuser(d_tuser[0]),
        .m_frame_len(d_frame_len[0]), .m_src_mac(d_src_mac[0]), .m_type(d_type[0]),
        .stat_accepted(d_acc[0]), .stat_dropped(d_drop[0])
    );

    eth_rx_word_packer #(.MAX_PAYLOAD(8)) dut_small (
        .clk(clk), .rst(rst), .cfg_local_mac(LocalMac), .cfg_promisc(cfg_promisc),
        .s_eth_hdr_valid(s_eth_hdr_valid && sel), .s_eth_hdr_ready(d_hdr_ready[1]),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_payload_tdata(s_payload_tdata), .s_payload_tvalid(s_payload_tvalid && sel),
        .s_payload_tready(d_pay_ready[1]), .s_payload_tlast(s_payload_tlast),
        .s_payload_tuser(s_payload_tuser), .m_tdata(d_tdata[1]), .m_tbytes(d_tbytes[1]),
        .m_tvalid(d_tvalid[1]), .m_tready(m_tready), .m_tlast(d_tlast[1]), .m_tuser(d_tuser[1]),
        .m_frame_len(d_frame_len[1]), .m_src_mac(d_src_mac[1]), .m_type(d_type[1]),
        .stat_accepted(d_acc[1]), .stat_dropped(d_drop[1])
    );

    // Observation follows whichever instance is currently selected.
    always_comb begin
        o_hdr_ready = d_hdr_ready[sel];
        o_pay_ready = d_pay_ready[sel];
        o_tvalid    = d_tvalid[sel];
        o_tlast     = d_tlast[sel];
        o_tuser     = d_tuser[sel];
        o_tdata     = d_tdata[sel];
        o_tbytes    = d_tbytes[sel];
        o_frame_len = d_frame_len[sel];
        o_type      = d_type[sel];
        o_src_mac   = d_src_mac[sel];
        o_acc       = d_acc[sel];
        o_drop      = d_drop[sel];
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard on handshakes, hold check while stalled.
    logic        stalled = 1'b0;
    logic [149:0] snap;
    always @(negedge clk) begin
        word_t e;
        if (stalled) begin
            check("stall_hold", {o_tvalid, o_tdata, o_tbytes, o_tlast, o_tuser, o_frame_len,
                                 o_src_mac, o_type}, {1'b1, snap});
        end
        if (o_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {o_tdata, o_tbytes}, 256'h1_0000_0000_0000_0000_0);
            end else begin
                e = exp_q.pop_front();
                check("word", {o_tdata, o_tbytes, o_tlast}, {e.data, e.bytes, e.last});
                check("meta", {o_src_mac, o_type, e.last ? {o_tuser, o_frame_len} : 17'd0},
                      {e.src, e.typ, e.last ? {e.user, e.len} : 17'd0});
            end
        end
        stalled = o_tvalid && !m_tready;
        snap = {o_tdata, o_tbytes, o_tlast, o_tuser, o_frame_len, o_src_mac, o_type};
    end

    task automatic hdr_beat(input logic [47:0] dest, input logic [47:0] src,
                            input logic [15:0] typ);
        bit ok = 0;
        s_eth_hdr_valid = 1'b1;
        s_eth_dest_mac = dest;
        s_eth_src_mac = src;
        s_eth_type = typ;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_hdr_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("hdr_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_eth_hdr_valid = 1'b0;
    endtask

    task automatic byte_beat(input logic [7:0] data, input logic last, input logic user,
                             input int gap);
        bit ok = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_payload_tvalid = 1'b1;
        s_payload_tdata = data;
        s_payload_tlast = last;
        s_payload_tuser = user;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_pay_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("byte_timeout", 0, 1);
        @(posedge clk);
        #1;
        s_payload_tvalid = 1'b0;
        s_payload_tlast = 1'b0;
        s_payload_tuser = 1'b0;
    endtask

    // Model: keep the first min(n, limit) bytes, cut into 8-byte words; the tlast beat closes
    // the frame, and if it was discarded it closes with whatever partial word remains.
    task automatic send_frame(input logic [47:0] dest, input int n, input logic tuser,
                              input bit rnd_data, input int max_gap);
        logic [7:0]  b[$];
        logic [47:0] src = {$urandom, $urandom};
        logic [15:0] typ = 16'($urandom);
        int          mx = sel ? 8 : 1500;
        int          kept = (n < mx) ? n : mx;
        bit          over = (n > mx);
        bit          acc_ok = cfg_promisc || dest == LocalMac || dest == 48'hFFFF_FFFF_FFFF;
        int          nw;
        word_t       w;
        for (int k = 0; k < n; k++) b.push_back(rnd_data ? 8'($urandom) : 8'(k));
        if (acc_ok) begin
            nw = over ? (kept / 8 + 1) : ((kept + 7) / 8);
            for (int i = 0; i < nw; i++) begin
                w = '0;
                w.bytes = 4'((kept - 8 * i) > 8 ? 8 : (kept - 8 * i));
                for (int k = 0; k < int'(w.bytes); k++) w.data[8*k +: 8] = b[8*i + k];
                w.last = (i == nw - 1);
                w.user = w.last && (tuser || over);
                w.len = w.last ? 16'((n > 65535) ? 65535 : n) : 16'd0;
                w.src = src;
                w.typ = typ;
                exp_q.push_back(w);
            end
            exp_acc[sel]++;
        end else begin
            exp_drop[sel]++;
        end
        hdr_beat(dest, src, typ);
        for (int k = 0; k < n; k++) begin
            byte_beat(b[k], k == n - 1, tuser, max_gap > 0 ? $urandom_range(0, max_gap) : 0);
        end
    endtask

    task automatic drain_and_check_stats(input string tag);
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !o_tvalid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check({tag, "_drain_timeout"}, 256'(exp_q.size()), 0);
        check({tag, "_stats"}, {o_acc, o_drop}, {32'(exp_acc[sel]), 32'(exp_drop[sel])});
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit stall_ok;
        logic [47:0] dest;
        exp_acc = '{0, 0};
        exp_drop = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("reset_state", {o_tvalid, o_tlast, o_tuser, o_acc, o_drop, o_hdr_ready},
                  {3'b000, 64'd0, 1'b1});
        end
        sel = 1'b0;
        @(posedge clk);
        #1;

        // 46-byte frame to the station address, bytes 0..45.
        send_frame(LocalMac, 46, 1'b0, 1'b0, 0);
        drain_and_check_stats("unicast46");

        // Frame to a foreign MAC is filtered; the next matching one goes through.
        send_frame(48'h0200_0000_0002, 20, 1'b0, 1'b1, 0);
        drain_and_check_stats("filtered");
        send_frame(LocalMac, 13, 1'b0, 1'b1, 1);
        drain_and_check_stats("after_drop");

        // Broadcast, sink stalls for 10 cycles once the first word is up.
        rdy_mode = 2;
        fork
            send_frame(48'hFFFF_FFFF_FFFF, 16, 1'b0, 1'b0, 0);
            begin
                stall_ok = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (o_tvalid) begin
                        stall_ok = 1;
                        break;
                    end
                end
                check("stall_word_seen", 256'(stall_ok), 1);
                repeat (10) @(negedge clk);
                check("stall_backpressure", {o_tvalid, o_pay_ready}, 2'b10);
                rdy_mode = 0;
            end
        join
        drain_and_check_stats("broadcast_stall");

        // Upstream bad-frame flag on a 9-byte frame.
        send_frame(LocalMac, 9, 1'b1, 1'b1, 0);
        drain_and_check_stats("tuser9");

        // Payload limit 8: 12 bytes give an 8-byte word and an empty closing word.
        sel = 1'b1;
        #1;
        send_frame(LocalMac, 12, 1'b0, 1'b0, 0);
        drain_and_check_stats("overflow12");
        send_frame(LocalMac, 11, 1'b0, 1'b1, 1);
        drain_and_check_stats("overflow11");

        // Randomised frames on both instances with random sink backpressure.
        rdy_mode = 1;
        for (int f = 0; f < 24; f++) begin
            sel = (f >= 14);
            #1;
            cfg_promisc = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0:       dest = LocalMac;
                1:       dest = 48'hFFFF_FFFF_FFFF;
                2:       dest = 48'h0200_0000_0003;
                default: dest = {$urandom, $urandom};
            endcase
            send_frame(dest, sel ? $urandom_range(1, 20) : $urandom_range(1, 40),
                       ($urandom_range(0, 4) == 0), 1'b1, 2);
            drain_and_check_stats("random");
        end
        rdy_mode = 0;
        cfg_promisc = 1'b0;
        sel = 1'b0;
        #1;

        // Reset after five payload bytes abandons the frame.
        hdr_beat(LocalMac, 48'h0A0B_0C0D_0E0F, 16'h0800);
        for (int k = 0; k < 5; k++) byte_beat(8'(8'hA0 + k), 1'b0, 1'b0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_acc = '{0, 0};
        exp_drop = '{0, 0};
        @(negedge clk);
        check("midframe_reset", {o_tvalid, o_acc, o_drop, o_hdr_ready}, {1'b0, 64'd0, 1'b1});
        @(posedge clk);
        #1;
        send_frame(LocalMac, 10, 1'b0, 1'b0, 0);
        drain_and_check_stats("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
